stage_sequencer: RTL and testbench

STAGE_SEQUENCER -- requirements
Module: stage_sequencer

---
 rtl/stage_sequencer_pkg.sv | 29 ++
 rtl/stall_timer.sv | 31 +++
 rtl/stage_sequencer.sv | 137 +++++++++++++
 tb/tb_stage_sequencer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/stage_sequencer_pkg.sv
// Shared types for the stage sequencer: state encoding,
// stageEn bit positions and the out-of-pipeline phase codes.
package stage_sequencer_pkg;

  localparam int WAIT_W = 8;

  localparam int B_FETCH  = 0;
  localparam int B_DECODE = 1;
  localparam int B_OPPREP = 2;
  localparam int B_EXEC   = 3;
  localparam int B_MEM    = 4;
  localparam int B_WB     = 5;

  localparam logic [2:0] PH_FAULT = 3'd6;
  localparam logic [2:0] PH_IDLE  = 3'd7;

  // Encoding doubles as the phase code.
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_OPPREP = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_FAULT  = PH_FAULT,
    S_IDLE   = PH_IDLE
  } state_t;

endpackage

// File: rtl/stall_timer.sv
// Wait-cycle counter for FETCH/MEM; flags the waiting cycle
// that would bring the count up to LIMIT.
module stall_timer
  import stage_sequencer_pkg::*;
#(
  parameter int LIMIT = 15
) (
  input  logic clock,
  input  logic resetN,
  input  logic clear,
  input  logic tick,
  output logic expire
);

  localparam logic [WAIT_W-1:0] LAST = WAIT_W'(LIMIT - 1);

  logic [WAIT_W-1:0] count;

  always_ff @(posedge clock) begin
    if (!resetN) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (tick) begin
      count <= count + 8'd1;
    end
  end

  assign expire = tick && (count == LAST);

endmodule

// File: rtl/stage_sequencer.sv
// Six-stage instruction sequencer with stall timeout.
// Optional perf counters under STAGE_SEQ_PERF_EN.
module stage_sequencer
  import stage_sequencer_pkg::*;
#(
  parameter int STALL_LIMIT = 15,
  parameter int PHASE_W     = 3
) (
  input  logic               clock,
  input  logic               resetN,
  input  logic               start,
  input  logic               halt,
  input  logic               icacheReady,
  input  logic               dcacheReady,
  input  logic               memReadFlag,
  input  logic               memWriteFlag,
  input  logic               regWrite,
  input  logic               faultClear,
  output logic [5:0]         stageEn,
  output logic [PHASE_W-1:0] phase,
  output logic               regWriteEn,
  output logic               pcAdvance,
  output logic               retirePulse,
  output logic               running,
  output logic               timeoutErr
`ifdef STAGE_SEQ_PERF_EN
  ,
  output logic [31:0]        cycleCount,
  output logic [31:0]        retireCount,
  output logic [31:0]        stallCount
`endif
);

  state_t state, state_n;
  logic   memOp, wbOp, haltQ;
  logic   waiting, entering, expire;

  assign waiting = (state == S_FETCH && !icacheReady)
                || (state == S_MEM && memOp && !dcacheReady);

  assign entering = (state_n != state)
                 && (state_n == S_FETCH || state_n == S_MEM);

  stall_timer #(
    .LIMIT (STALL_LIMIT)
  ) u_timer (
    .clock  (clock),
    .resetN (resetN),
    .clear  (entering),
    .tick   (waiting),
    .expire (expire)
  );

  always_ff @(posedge clock) begin
    if (!resetN) begin
      state <= S_IDLE;
      memOp <= 1'b0;
      wbOp  <= 1'b0;
      haltQ <= 1'b0;
    end else begin
      state <= state_n;
      if (state == S_DECODE) begin
        memOp <= memReadFlag | memWriteFlag;
        wbOp  <= regWrite;
      end
      // Idle never latches halt unless start moves us out.
      haltQ <= (state_n != S_IDLE) && (haltQ || halt);
    end
  end

  always_comb begin
    state_n     = state;
    stageEn     = '0;
    regWriteEn  = 1'b0;
    pcAdvance   = 1'b0;
    retirePulse = 1'b0;
    running     = 1'b1;
    timeoutErr  = 1'b0;
    unique case (state)
      S_IDLE: begin
        running = 1'b0;
        if (start) state_n = S_FETCH;
      end
      S_FETCH: begin
        stageEn[B_FETCH] = 1'b1;
        if (icacheReady) state_n = S_DECODE;
        else if (expire) state_n = S_FAULT;
      end
      S_DECODE: begin
        stageEn[B_DECODE] = 1'b1;
        state_n = S_OPPREP;
      end
      S_OPPREP: begin
        stageEn[B_OPPREP] = 1'b1;
        state_n = S_EXEC;
      end
      S_EXEC: begin
        stageEn[B_EXEC] = 1'b1;
        state_n = S_MEM;
      end
      S_MEM: begin
        stageEn[B_MEM] = 1'b1;
        if (!memOp || dcacheReady) state_n = S_WB;
        else if (expire) state_n = S_FAULT;
      end
      S_WB: begin
        stageEn[B_WB] = 1'b1;
        regWriteEn    = wbOp;
        pcAdvance     = 1'b1;
        retirePulse   = 1'b1;
        state_n = (haltQ || halt) ? S_IDLE : S_FETCH;
      end
      S_FAULT: begin
        running    = 1'b0;
        timeoutErr = 1'b1;
        if (faultClear) state_n = S_IDLE;
      end
    endcase
  end

  assign phase = PHASE_W'(state);

`ifdef STAGE_SEQ_PERF_EN
  always_ff @(posedge clock) begin
    if (!resetN) begin
      cycleCount  <= '0;
      retireCount <= '0;
      stallCount  <= '0;
    end else begin
      if (running)     cycleCount  <= cycleCount + 32'd1;
      if (retirePulse) retireCount <= retireCount + 32'd1;
      if (waiting)     stallCount  <= stallCount + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed bench for stage_sequencer (STALL_LIMIT=4).
// Perf counter checks compile in with STAGE_SEQ_PERF_EN.
module tb_stage_sequencer;

  logic       clock = 1'b0;
  logic       resetN, start, halt;
  logic       icacheReady, dcacheReady;
  logic       memReadFlag, memWriteFlag, regWrite;
  logic       faultClear;
  logic [5:0] stageEn;
  logic [2:0] phase;
  logic       regWriteEn, pcAdvance, retirePulse;
  logic       running, timeoutErr;
`ifdef STAGE_SEQ_PERF_EN
  logic [31:0] cycleCount, retireCount, stallCount;
  logic [31:0] s0;
`endif

  int nchk  = 0;
  int npass = 0;

  stage_sequencer #(
    .STALL_LIMIT (4),
    .PHASE_W     (3)
  ) dut (
    .clock        (clock),
    .resetN       (resetN),
    .start        (start),
    .halt         (halt),
    .icacheReady  (icacheReady),
    .dcacheReady  (dcacheReady),
    .memReadFlag  (memReadFlag),
    .memWriteFlag (memWriteFlag),
    .regWrite     (regWrite),
    .faultClear   (faultClear),
    .stageEn      (stageEn),
    .phase        (phase),
    .regWriteEn   (regWriteEn),
    .pcAdvance    (pcAdvance),
    .retirePulse  (retirePulse),
    .running      (running),
    .timeoutErr   (timeoutErr)
`ifdef STAGE_SEQ_PERF_EN
    ,
    .cycleCount   (cycleCount),
    .retireCount  (retireCount),
    .stallCount   (stallCount)
`endif
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    resetN = 1'b0; start = 1'b0; halt = 1'b0;
    icacheReady = 1'b0; dcacheReady = 1'b0;
    memReadFlag = 1'b0; memWriteFlag = 1'b0;
    regWrite = 1'b0; faultClear = 1'b0;
    step(2);
    chk("rst_phase", phase, 7);
    chk("rst_stage", stageEn, 0);
    chk("rst_run", running, 0);
    chk("rst_tmo", timeoutErr, 0);
    chk("rst_strb", {regWriteEn, pcAdvance, retirePulse}, 0);
    resetN = 1'b1;
    step();
    chk("idle_hold", phase, 7);

    // Zero-wait instruction, then a halted one with regWrite=0.
    icacheReady = 1'b1; dcacheReady = 1'b1; regWrite = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("t1_stage", stageEn, 32'(6'd1 << i));
      if (i == 0) chk("t1_noretire", retirePulse, 0);
      if (i == 5) begin
        chk("t1_rwen", regWriteEn, 1);
        chk("t1_retire", retirePulse, 1);
        chk("t1_pcadv", pcAdvance, 1);
      end
      step();
    end
    chk("t1_refetch", phase, 0);
    chk("t1_run", running, 1);
    halt = 1'b1; regWrite = 1'b0;
    step();
    halt = 1'b0;
    chk("t1_decode", phase, 1);
    step(4);
    chk("t1b_wb", phase, 5);
    chk("t1b_rwen", regWriteEn, 0);
    chk("t1b_retire", retirePulse, 1);
    step();
    chk("t1b_idle", phase, 7);
    chk("t1b_run", running, 0);

    // Memory read with three dcache wait cycles.
    memReadFlag = 1'b1; regWrite = 1'b1; dcacheReady = 1'b0;
`ifdef STAGE_SEQ_PERF_EN
    s0 = stallCount;
`endif
    start = 1'b1;
    step();
    start = 1'b0; halt = 1'b1;
    step();
    halt = 1'b0;
    step(3);
    chk("t2_mem", phase, 4);
    step(3);
    chk("t2_mem_hold", phase, 4);
    dcacheReady = 1'b1;
    step();
    chk("t2_wb", phase, 5);
    chk("t2_retire", retirePulse, 1);
    chk("t2_rwen", regWriteEn, 1);
`ifdef STAGE_SEQ_PERF_EN
    chk("t2_stalls", stallCount - s0, 3);
`endif
    step();
    chk("t2_idle", phase, 7);

    // Fetch timeout into FAULT and recovery.
    memReadFlag = 1'b0; icacheReady = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    step(3);
    chk("t3_fetch", phase, 0);
    step();
    chk("t3_fault", phase, 6);
    chk("t3_tmo", timeoutErr, 1);
    chk("t3_stage", stageEn, 0);
    chk("t3_run", running, 0);
    chk("t3_strb", {regWriteEn, pcAdvance, retirePulse}, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t3_fault_hold", phase, 6);
    faultClear = 1'b1;
    step();
    faultClear = 1'b0;
    chk("t3_idle", phase, 7);
    chk("t3_tmo_clr", timeoutErr, 0);

    // Ready on the last allowed wait cycle wins.
    start = 1'b1;
    step();
    start = 1'b0;
    step(3);
    chk("t4_fetch", phase, 0);
    icacheReady = 1'b1; halt = 1'b1;
    step();
    halt = 1'b0;
    chk("t4_decode", phase, 1);
    chk("t4_tmo", timeoutErr, 0);
    step(4);
    chk("t4_retire", retirePulse, 1);
    step();
    chk("t4_idle", phase, 7);

    // Halt during EXEC.
    start = 1'b1;
    step();
    start = 1'b0;
    step(3);
    chk("t5_exec", phase, 3);
    halt = 1'b1;
    step();
    halt = 1'b0;
    chk("t5_mem", phase, 4);
    step();
    chk("t5_retire", retirePulse, 1);
    step();
    chk("t5_idle", phase, 7);
    chk("t5_run", running, 0);

    // Halt in IDLE ignored; start+halt runs one instruction.
    halt = 1'b1;
    step();
    halt = 1'b0;
    chk("t6_idle_halt", phase, 7);
    start = 1'b1;
    step();
    start = 1'b0;
    step(5);
    chk("t6_wb", phase, 5);
    step();
    chk("t6_continue", phase, 0);
    halt = 1'b1;
    step();
    halt = 1'b0;
    step(4);
    step();
    chk("t6_stop", phase, 7);
    start = 1'b1; halt = 1'b1;
    step();
    start = 1'b0; halt = 1'b0;
    chk("t6_fetch", phase, 0);
    step(5);
    chk("t6_retire", retirePulse, 1);
    step();
    chk("t6_one_instr", phase, 7);

    // Reset in the middle of a MEM wait.
    memReadFlag = 1'b1; dcacheReady = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    step(5);
    chk("t7_memwait", phase, 4);
    resetN = 1'b0;
    step();
    resetN = 1'b1;
    chk("t7_phase", phase, 7);
    chk("t7_stage", stageEn, 0);
    chk("t7_run", running, 0);
    chk("t7_tmo", timeoutErr, 0);
    chk("t7_strb", {regWriteEn, pcAdvance, retirePulse}, 0);
`ifdef STAGE_SEQ_PERF_EN
    chk("t7_cyc", cycleCount, 0);
    chk("t7_ret", retireCount, 0);
    chk("t7_stl", stallCount, 0);
`endif
    dcacheReady = 1'b1;
    step();
    chk("t7_idle", phase, 7);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
